// File: rtl/mssd_gen.sv
// mssd_gen: a serial frame demultiplexer.
// Each frame is: start bit (0), channel field, length field, then payload bits.
// Every payload bit is routed to one of 2**CH_BITS channels with a
// one-cycle valid strobe. Zero-length frames, abort and back-to-back
// frames are supported.
module mssd_gen #(
    parameter int unsigned CH_BITS  = 2,
    parameter int unsigned LEN_BITS = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      clk_en,
    input  logic                      ser_in,
    input  logic                      abort,
    output logic                      data_out,
    output logic [(2**CH_BITS)-1:0]   ch_valid,
    output logic [(2**CH_BITS)-1:0]   port_onehot,
    output logic [LEN_BITS-1:0]       rem_len,
    output logic                      busy,
    output logic                      done,
    output logic                      aborted
);

    localparam int unsigned NCH   = 2**CH_BITS;
    localparam int unsigned MAXB  = (CH_BITS > LEN_BITS) ? CH_BITS : LEN_BITS;
    localparam int unsigned CNT_W = $clog2(MAXB + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CHAN = 2'd1,
        S_LEN  = 2'd2,
        S_DATA = 2'd3
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;

    logic [CH_BITS-1:0]    r_ch_sh;
    logic [LEN_BITS-1:0]   r_len_sh;
    logic [CNT_W-1:0]      r_bit_cnt;
    logic                  r_data_out;
    logic [NCH-1:0]        r_ch_valid;
    logic [NCH-1:0]        r_port_onehot;
    logic [LEN_BITS-1:0]   r_rem_len;
    logic                  r_done;
    logic                  r_aborted;

    logic [CH_BITS-1:0]    w_ch_sh_nxt;
    logic [LEN_BITS-1:0]   w_len_sh_nxt;
    logic [CNT_W-1:0]      w_bit_cnt_nxt;
    logic                  w_data_out_nxt;
    logic [NCH-1:0]        w_ch_valid_nxt;
    logic [NCH-1:0]        w_port_onehot_nxt;
    logic [LEN_BITS-1:0]   w_rem_len_nxt;
    logic                  w_done_nxt;
    logic                  w_aborted_nxt;

    // Field values including the bit being sampled this cycle
    logic [CH_BITS-1:0]    w_ch_shift;
    logic [LEN_BITS-1:0]   w_len_shift;

    assign w_ch_shift  = CH_BITS'({r_ch_sh, ser_in});
    assign w_len_shift = LEN_BITS'({r_len_sh, ser_in});

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and next-output logic; abort overrides the bit sample
    always_comb begin
        w_state_nxt       = r_state;
        w_ch_sh_nxt       = r_ch_sh;
        w_len_sh_nxt      = r_len_sh;
        w_bit_cnt_nxt     = r_bit_cnt;
        w_data_out_nxt    = r_data_out;
        w_ch_valid_nxt    = '0;
        w_port_onehot_nxt = r_port_onehot;
        w_rem_len_nxt     = r_rem_len;
        w_done_nxt        = 1'b0;
        w_aborted_nxt     = 1'b0;

        if (abort && (r_state != S_IDLE)) begin
            w_state_nxt   = S_IDLE;
            w_aborted_nxt = 1'b1;
            w_rem_len_nxt = '0;
            w_bit_cnt_nxt = '0;
        end else if (clk_en) begin
            case (r_state)
                S_IDLE: begin
                    if (!ser_in) begin
                        w_state_nxt   = S_CHAN;
                        w_bit_cnt_nxt = '0;
                    end
                end
                S_CHAN: begin
                    w_ch_sh_nxt = w_ch_shift;
                    if (r_bit_cnt == CNT_W'(CH_BITS - 1)) begin
                        w_port_onehot_nxt = NCH'(1) << w_ch_shift;
                        w_bit_cnt_nxt     = '0;
                        w_state_nxt       = S_LEN;
                    end else begin
                        w_bit_cnt_nxt = r_bit_cnt + CNT_W'(1);
                    end
                end
                S_LEN: begin
                    w_len_sh_nxt = w_len_shift;
                    if (r_bit_cnt == CNT_W'(LEN_BITS - 1)) begin
                        w_bit_cnt_nxt = '0;
                        if (w_len_shift == '0) begin
                            w_done_nxt    = 1'b1;
                            w_rem_len_nxt = '0;
                            w_state_nxt   = S_IDLE;
                        end else begin
                            w_rem_len_nxt = w_len_shift;
                            w_state_nxt   = S_DATA;
                        end
                    end else begin
                        w_bit_cnt_nxt = r_bit_cnt + CNT_W'(1);
                    end
                end
                S_DATA: begin
                    w_data_out_nxt = ser_in;
                    w_ch_valid_nxt = r_port_onehot;
                    w_rem_len_nxt  = r_rem_len - LEN_BITS'(1);
                    if (r_rem_len == LEN_BITS'(1)) begin
                        w_done_nxt  = 1'b1;
                        w_state_nxt = S_IDLE;
                    end
                end
                default: begin
                    w_state_nxt = S_IDLE;
                end
            endcase
        end
    end

    // Datapath and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ch_sh       <= '0;
            r_len_sh      <= '0;
            r_bit_cnt     <= '0;
            r_data_out    <= 1'b0;
            r_ch_valid    <= '0;
            r_port_onehot <= '0;
            r_rem_len     <= '0;
            r_done        <= 1'b0;
            r_aborted     <= 1'b0;
        end else begin
            r_ch_sh       <= w_ch_sh_nxt;
            r_len_sh      <= w_len_sh_nxt;
            r_bit_cnt     <= w_bit_cnt_nxt;
            r_data_out    <= w_data_out_nxt;
            r_ch_valid    <= w_ch_valid_nxt;
            r_port_onehot <= w_port_onehot_nxt;
            r_rem_len     <= w_rem_len_nxt;
            r_done        <= w_done_nxt;
            r_aborted     <= w_aborted_nxt;
        end
    end

    assign data_out    = r_data_out;
    assign ch_valid    = r_ch_valid;
    assign port_onehot = r_port_onehot;
    assign rem_len     = r_rem_len;
    assign done        = r_done;
    assign aborted     = r_aborted;
    assign busy        = (r_state != S_IDLE);

endmodule

// File: tb/tb_mssd_gen.sv
// Testbench for mssd_gen (CH_BITS=2, LEN_BITS=4).
// Frames are described as (channel, length, payload). Each frame is expanded
// into a list of serial samples, and every sample carries the effect it must
// produce. The bench then compares the outputs every cycle.
module tb_mssd_gen;

    logic       clk = 1'b0;
    logic       rst;
    logic       clk_en;
    logic       ser_in;
    logic       abort;
    logic       data_out;
    logic [3:0] ch_valid;
    logic [3:0] port_onehot;
    logic [3:0] rem_len;
    logic       busy;
    logic       done;
    logic       aborted;

    int n_cmp = 0;
    int n_err = 0;

    mssd_gen #(.CH_BITS(2), .LEN_BITS(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .clk_en      (clk_en),
        .ser_in      (ser_in),
        .abort       (abort),
        .data_out    (data_out),
        .ch_valid    (ch_valid),
        .port_onehot (port_onehot),
        .rem_len     (rem_len),
        .busy        (busy),
        .done        (done),
        .aborted     (aborted)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       b;
        logic       strobe;
        logic       dn;
        logic       port_upd;
        logic [3:0] port;
        logic       rem_upd;
        logic [3:0] rem;
        logic       busy_after;
    } samp_t;

    samp_t q[$];

    // Expected held outputs
    logic [3:0] m_port = '0;
    logic [3:0] m_rem  = '0;
    logic       m_data = 1'b0;
    logic       m_busy = 1'b0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    function automatic samp_t blank(input logic b, input logic bz);
        samp_t s;
        s.b = b; s.strobe = 1'b0; s.dn = 1'b0; s.port_upd = 1'b0; s.port = '0;
        s.rem_upd = 1'b0; s.rem = '0; s.busy_after = bz;
        return s;
    endfunction

    task automatic add_idle(input int n);
        for (int i = 0; i < n; i++) q.push_back(blank(1'b1, 1'b0));
    endtask

    // payload[j] is the j-th payload bit on the wire
    task automatic add_frame(input int ch, input int len, input logic [15:0] payload);
        samp_t s;
        logic [1:0] chv;
        logic [3:0] lv;
        chv = 2'(ch);
        lv  = 4'(len);
        q.push_back(blank(1'b0, 1'b1));
        for (int i = 1; i >= 0; i--) begin
            s = blank(chv[i], 1'b1);
            if (i == 0) begin
                s.port_upd = 1'b1;
                s.port     = 4'(1 << ch);
            end
            q.push_back(s);
        end
        for (int i = 3; i >= 0; i--) begin
            s = blank(lv[i], 1'b1);
            if (i == 0) begin
                s.rem_upd = 1'b1;
                s.rem     = lv;
                if (len == 0) begin
                    s.dn = 1'b1;
                    s.busy_after = 1'b0;
                end
            end
            q.push_back(s);
        end
        for (int j = 0; j < len; j++) begin
            s = blank(payload[j], (j != len - 1));
            s.strobe  = 1'b1;
            s.rem_upd = 1'b1;
            s.rem     = 4'(len - 1 - j);
            s.dn      = (j == len - 1);
            q.push_back(s);
        end
    endtask

    task automatic check_all(input logic [3:0] e_valid, input logic e_done);
        chk("data_out", 32'(data_out), 32'(m_data));
        chk("ch_valid", 32'(ch_valid), 32'(e_valid));
        chk("port_onehot", 32'(port_onehot), 32'(m_port));
        chk("rem_len", 32'(rem_len), 32'(m_rem));
        chk("busy", 32'(busy), 32'(m_busy));
        chk("done", 32'(done), 32'(e_done));
        chk("aborted", 32'(aborted), 32'(0));
    endtask

    // mode 0: clk_en every cycle, 1: every 4th cycle, 2: random
    task automatic run_queue(input int mode);
        int    c;
        logic  en;
        samp_t s;
        logic [3:0] e_valid;
        logic  e_done;
        c = 0;
        while (q.size() != 0) begin
            case (mode)
                0:       en = 1'b1;
                1:       en = ((c % 4) == 0);
                default: en = ($urandom_range(0, 2) != 0);
            endcase
            c++;
            clk_en = en;
            abort  = 1'b0;
            if (en) begin
                s = q.pop_front();
                ser_in = s.b;
            end else begin
                s = blank(1'b1, m_busy);
                ser_in = 1'($urandom_range(0, 1));
            end
            @(posedge clk);
            #1;
            e_valid = '0;
            e_done  = 1'b0;
            if (en) begin
                if (s.port_upd) m_port = s.port;
                if (s.rem_upd) m_rem = s.rem;
                if (s.strobe) begin
                    m_data  = s.b;
                    e_valid = m_port;
                end
                e_done = s.dn;
                m_busy = s.busy_after;
            end
            check_all(e_valid, e_done);
        end
        clk_en = 1'b0;
    endtask

    task automatic step(input logic en, input logic b, input logic ab);
        clk_en = en;
        ser_in = b;
        abort  = ab;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; clk_en = 1'b0; ser_in = 1'b1; abort = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_port", 32'(port_onehot), 32'(0));
        chk("rst_rem", 32'(rem_len), 32'(0));
        chk("rst_valid", 32'(ch_valid), 32'(0));
        rst = 1'b0;

        // Idle line, then the basic frame: ch 2, length 3, payload 1,0,1
        add_idle(10);
        run_queue(0);
        add_frame(2, 3, 16'b101);
        run_queue(0);
        // Zero-length frame on ch 3
        add_frame(3, 0, 16'h0);
        run_queue(0);
        // Back-to-back frames
        add_frame(0, 1, 16'b1);
        add_frame(3, 1, 16'b0);
        run_queue(0);
        // Sparse clk_en
        add_frame(2, 3, 16'b101);
        run_queue(1);

        // Abort during 2nd payload bit of a len=5 frame on ch 1
        step(1, 0, 0);
        step(1, 0, 0); step(1, 1, 0);
        step(1, 0, 0); step(1, 1, 0); step(1, 0, 0); step(1, 1, 0);
        chk("ab_rem5", 32'(rem_len), 32'(5));
        chk("ab_port", 32'(port_onehot), 32'(4'b0010));
        step(1, 1, 0);
        chk("ab_valid1", 32'(ch_valid), 32'(4'b0010));
        chk("ab_data1", 32'(data_out), 32'(1));
        step(1, 0, 1);
        chk("ab_aborted", 32'(aborted), 32'(1));
        chk("ab_done", 32'(done), 32'(0));
        chk("ab_valid2", 32'(ch_valid), 32'(0));
        chk("ab_busy", 32'(busy), 32'(0));
        chk("ab_rem0", 32'(rem_len), 32'(0));
        chk("ab_port_hold", 32'(port_onehot), 32'(4'b0010));
        step(0, 0, 0);
        chk("ab_pulse_width", 32'(aborted), 32'(0));
        step(1, 1, 1);
        chk("ab_idle_noeffect", 32'(aborted), 32'(0));
        chk("ab_idle_busy", 32'(busy), 32'(0));
        abort = 1'b0;
        m_port = 4'b0010; m_rem = '0; m_data = 1'b1; m_busy = 1'b0;
        add_frame(3, 2, 16'b10);
        run_queue(0);

        // Reset while receiving the length field
        step(1, 0, 0); step(1, 1, 0); step(1, 1, 0); step(1, 0, 0);
        chk("rl_busy_pre", 32'(busy), 32'(1));
        rst = 1'b1; clk_en = 1'b1; ser_in = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rl_busy", 32'(busy), 32'(0));
        chk("rl_port", 32'(port_onehot), 32'(0));
        chk("rl_rem", 32'(rem_len), 32'(0));
        chk("rl_valid", 32'(ch_valid), 32'(0));
        chk("rl_data", 32'(data_out), 32'(0));
        chk("rl_done", 32'(done), 32'(0));
        chk("rl_aborted", 32'(aborted), 32'(0));
        step(1, 1, 0);
        chk("rl_done2", 32'(done), 32'(0));
        chk("rl_aborted2", 32'(aborted), 32'(0));
        chk("rl_busy2", 32'(busy), 32'(0));
        m_port = '0; m_rem = '0; m_data = 1'b0; m_busy = 1'b0;

        // Random frames with random clk_en
        for (int k = 0; k < 30; k++) begin
            add_idle($urandom_range(0, 2));
            add_frame($urandom_range(0, 3),
                      ($urandom_range(0, 5) == 0) ? 0 : $urandom_range(1, 15),
                      16'($urandom));
        end
        add_idle(3);
        run_queue(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
